fir_bank_sched: RTL and testbench

Round-robin scheduler that shares one bank-switched FIR MAC engine (41 taps, 24-bit, one engine with a per-channel delay-line bank) between `N_CH` independent sample streams. It sits between the per-channel ADC sample ticks and the engine. It holds each new sample, issues it to the engine with its bank index, and waits for completion. It then returns the filtered result to the originating channel with a one-cycle valid strobe.

---
 rtl/fir_bank_sched.sv | 140 ++++++++++++++
 tb/tb_fir_bank_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_bank_sched.sv
// Round-robin scheduler sharing one bank-switched FIR engine between N_CH sample streams.
// Optional engine watchdog enabled by defining FIR_SCHED_TIMEOUT_EN.
module fir_bank_sched #(
  parameter int N_CH        = 4,
  parameter int DATA_W      = 24,
  parameter int DRAIN_CYC   = 48,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_CH-1:0]          tick_i,
  input  logic [N_CH*DATA_W-1:0]   signal_i,
  output logic [N_CH*DATA_W-1:0]   signal_o,
  output logic [N_CH-1:0]          valid_o,
  output logic [N_CH-1:0]          overrun_o,
  input  logic                     clr_i,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic                     fir_tick_o,
  output logic [$clog2(N_CH)-1:0]  fir_ch_o,
  output logic [DATA_W-1:0]        fir_signal_o,
  input  logic                     fir_done_i,
  input  logic [DATA_W-1:0]        fir_signal_i,
  output logic [2:0]               state_o
);

  localparam int CH_W = $clog2(N_CH);
  localparam int DC_W = $clog2(DRAIN_CYC + 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  // Engine handshake: fir_tick_o is a one-cycle start strobe with fir_ch_o/fir_signal_o valid
  // in that cycle; fir_done_i is a one-cycle strobe and fir_signal_i is valid the cycle after.
  state_t               state_q, state_d;
  logic [DC_W-1:0]      drain_cnt;
  logic [N_CH-1:0]      pending;
  logic [DATA_W-1:0]    hold [N_CH];
  logic [CH_W-1:0]      grant_q, last_grant, grant_next;
  logic                 grant_found;
  logic                 to_hit;

  // Lowest offset from last_grant+1 wins, so scan offsets downward and let the last hit stand.
  always_comb begin
    logic [CH_W-1:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_next  = '0;
    for (int i = N_CH; i >= 1; i--) begin
      cand = CH_W'((int'(last_grant) + i) % N_CH);
      if (pending[cand]) begin
        grant_found = 1'b1;
        grant_next  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DRAIN: if (drain_cnt == DRAIN_LAST) state_d = S_IDLE;
      S_IDLE:  if (grant_found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (fir_done_i) state_d = S_WB;
        else if (to_hit) state_d = S_DRAIN;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_DRAIN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_DRAIN;
      drain_cnt  <= '0;
      grant_q    <= '0;
      last_grant <= CH_W'(N_CH - 1);
      pending    <= '0;
      overrun_o  <= '0;
      valid_o    <= '0;
      signal_o   <= '0;
      for (int c = 0; c < N_CH; c++) hold[c] <= '0;
    end else begin
      state_q   <= state_d;
      drain_cnt <= (state_q == S_DRAIN) ? drain_cnt + 1'b1 : '0;
      valid_o   <= '0;
      if (state_q == S_IDLE && grant_found) grant_q <= grant_next;
      if (state_q == S_ISSUE) last_grant <= grant_q;
      for (int c = 0; c < N_CH; c++) begin
        if (clr_i) overrun_o[c] <= 1'b0;
        if (state_q == S_ISSUE && grant_q == CH_W'(c)) pending[c] <= 1'b0;
        // A tick in the issue cycle of its own channel re-arms pending without an overrun.
        if (tick_i[c]) begin
          hold[c]    <= signal_i[c*DATA_W +: DATA_W];
          pending[c] <= 1'b1;
          if (pending[c] && !(state_q == S_ISSUE && grant_q == CH_W'(c)))
            overrun_o[c] <= 1'b1;
        end
        if (state_q == S_WB && grant_q == CH_W'(c)) begin
          signal_o[c*DATA_W +: DATA_W] <= fir_signal_i;
          valid_o[c]                   <= 1'b1;
        end
      end
    end
  end

`ifdef FIR_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt;
  logic            timeout_q;

  // to_cnt equals the number of cycles elapsed since the issue cycle while in WAIT.
  assign to_hit    = (state_q == S_WAIT) && !fir_done_i && (to_cnt == TO_LAST);
  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == S_ISSUE) to_cnt <= TO_W'(1);
      else if (state_q == S_WAIT) to_cnt <= to_cnt + 1'b1;
      if (clr_i) timeout_q <= 1'b0;
      if (to_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign busy_o       = (state_q != S_IDLE);
  assign fir_tick_o   = (state_q == S_ISSUE);
  assign fir_ch_o     = grant_q;
  assign fir_signal_o = (state_q == S_ISSUE) ? hold[grant_q] : '0;
  assign state_o      = state_q;

endmodule

// File: tb/tb_fir_bank_sched.sv
// Testbench for fir_bank_sched: directed scenarios plus random ticks against an event-level model.
module tb_fir_bank_sched;
  localparam int N = 4, DW = 24, CHW = 2, LAT = 44, VLAT = 46;
  localparam logic [DW-1:0] MASK = 24'hA50F3C;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic [N-1:0]    tick = '0;
  logic [N*DW-1:0] sig = '0;
  logic            clr = 1'b0;
  logic            fir_done = 1'b0;
  logic [DW-1:0]   fir_res = '0;
  logic [N*DW-1:0] signal_o;
  logic [N-1:0]    valid, overrun;
  logic            busy, timeout, fir_tick;
  logic [CHW-1:0]  fir_ch;
  logic [DW-1:0]   fir_sig;
  logic [2:0]      dbg_state;

  fir_bank_sched #(.N_CH(N), .DATA_W(DW), .DRAIN_CYC(48), .TIMEOUT_CYC(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .signal_i(sig), .signal_o(signal_o),
    .valid_o(valid), .overrun_o(overrun), .clr_i(clr), .busy_o(busy), .timeout_o(timeout),
    .fir_tick_o(fir_tick), .fir_ch_o(fir_ch), .fir_signal_o(fir_sig),
    .fir_done_i(fir_done), .fir_signal_i(fir_res), .state_o(dbg_state)
  );

  int total = 0, bad = 0, cyc = 0;

  // reference model and scoreboard
  logic [DW-1:0] m_hold [N];
  logic [DW-1:0] m_out [N];
  logic [N-1:0]  m_pend, m_ovr, pend_prev;
  logic          m_to;
  int            m_last;
  logic [DW-1:0] exp_q[$];
  int            job_ch, job_issue;
  bit            job_dead;
  int            issue_q[$];
  int            last_issue = -1;

  // engine model (independent of scheduler reset)
  int            eng_cnt = 0;
  bit            eng_dead = 0, res_next = 0, force_on = 0;
  logic [DW-1:0] eng_res = '0, force_val = '0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_pend = '0; m_ovr = '0; m_to = 1'b0; m_last = N - 1; pend_prev = '0;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin m_hold[k] = '0; m_out[k] = '0; end
  endfunction

  function automatic int next_grant();
    for (int k = 1; k <= N; k++)
      if (pend_prev[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  function automatic logic [N*DW-1:0] pack_out();
    logic [N*DW-1:0] p;
    for (int k = 0; k < N; k++) p[k*DW +: DW] = m_out[k];
    return p;
  endfunction

  // driver: one clock cycle with the given inputs, observing the DUT outputs of that cycle
  task automatic step(input logic [N-1:0] t, input logic [N*DW-1:0] s, input logic c);
    logic iss; logic [CHW-1:0] ich; logic [DW-1:0] isig; logic [N-1:0] vld, ev;
    logic [N*DW-1:0] so; logic [N-1:0] snap; int g; bit rst_edge;
    iss = fir_tick; ich = fir_ch; isig = fir_sig; vld = valid; so = signal_o;
    snap = m_pend; rst_edge = !rst_n;
    fir_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin fir_done = 1'b1; fir_res = ~eng_res; res_next = 1; end
    end else if (res_next) begin
      fir_res = eng_res; res_next = 0;
    end
    tick = t; sig = s; clr = c;

    if (vld != '0) begin
      if (exp_q.size() == 0) check_eq("valid_unexpected", vld, '0);
      else begin
        ev = '0; ev[job_ch] = 1'b1;
        check_eq("valid_ch", vld, ev);
        check_eq("valid_latency", cyc - job_issue, VLAT);
        m_out[job_ch] = exp_q.pop_front();
      end
    end else if (exp_q.size() > 0 && !job_dead && cyc - job_issue > VLAT) begin
      ev = '0; ev[job_ch] = 1'b1;
      check_eq("valid_missing", vld, ev);
      void'(exp_q.pop_front());
    end
    check_eq("signal_o", so, pack_out());
    if (exp_q.size() > 0) check_eq("busy_job", busy, 1'b1);

    if (iss) begin
      g = next_grant();
      check_eq("issue_while_job", exp_q.size(), 0);
      if (g < 0) check_eq("issue_none_pending", iss, 1'b0);
      else begin
        check_eq("issue_ch", ich, g);
        check_eq("issue_sig", isig, m_hold[g]);
        m_pend[g] = 1'b0; m_last = g; job_ch = g; job_issue = cyc; job_dead = eng_dead;
        exp_q.push_back(force_on ? force_val : (m_hold[g] ^ MASK));
      end
      issue_q.push_back(int'(ich)); last_issue = cyc;
      if (!eng_dead) begin eng_cnt = LAT; eng_res = force_on ? force_val : (isig ^ MASK); end
    end

    if (c) begin m_ovr = '0; m_to = 1'b0; end
`ifdef FIR_SCHED_TIMEOUT_EN
    if (exp_q.size() > 0 && job_dead && cyc == job_issue + 63) begin m_to = 1'b1; exp_q.delete(); end
`endif
    for (int k = 0; k < N; k++)
      if (t[k]) begin
        if (m_pend[k]) m_ovr[k] = 1'b1;
        m_hold[k] = s[k*DW +: DW]; m_pend[k] = 1'b1;
      end
    pend_prev = snap;

    @(posedge clk); #1; cyc++;
    if (rst_edge) begin
      model_reset();
      check_eq("rst_fir_tick", fir_tick, 1'b0);
      check_eq("rst_fir_ch", fir_ch, '0);
      check_eq("rst_fir_sig", fir_sig, '0);
      check_eq("rst_valid", valid, '0);
      check_eq("rst_signal_o", signal_o, '0);
      check_eq("rst_busy", busy, 1'b1);
    end
    check_eq("overrun", overrun, m_ovr);
    check_eq("timeout", timeout, m_to);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, sig, 1'b0);
  endtask

  task automatic tick_one(input int ch, input logic [DW-1:0] v);
    logic [N-1:0] t; logic [N*DW-1:0] s;
    t = '0; t[ch] = 1'b1; s = sig; s[ch*DW +: DW] = v;
    step(t, s, 1'b0);
  endtask

  task automatic wait_issue(input int maxc, output int at);
    int n0;
    n0 = issue_q.size();
    for (int i = 0; i < maxc && issue_q.size() == n0; i++) step('0, sig, 1'b0);
    if (issue_q.size() == n0) check_eq("issue_wait_expired", issue_q.size(), n0 + 1);
    at = last_issue;
  endtask

  initial begin
    int r, k, at, at2, n1;
    logic [N-1:0] t; logic [N*DW-1:0] s;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // reset, drain period, first issue, fixed engine result
    rst_n = 1'b0; idle(2); rst_n = 1'b1;
    r = cyc;
    idle(5);
    force_on = 1; force_val = 24'h123456;
    tick_one(0, 24'h000100);
    wait_issue(100, at);
    force_on = 0;
    check_eq("drain_first_issue", at, r + 49);
    check_eq("first_issue_ch", issue_q[$], 0);
    idle(50);
    check_eq("ch0_result", signal_o[DW-1:0], 24'h123456);

    // minimum tick-to-issue latency
    k = cyc;
    tick_one(1, 24'h000777);
    wait_issue(10, at);
    check_eq("tick_to_issue", at, k + 2);
    idle(50);

    // simultaneous ticks on 3,1,2 after channel 1 was served
    s = sig;
    for (int c = 0; c < N; c++) s[c*DW +: DW] = DW'($urandom);
    step(4'b1110, s, 1'b0);
    for (int i = 0; i < 3; i++) wait_issue(100, at);
    check_eq("rr_order_0", issue_q[issue_q.size()-3], 2);
    check_eq("rr_order_1", issue_q[issue_q.size()-2], 3);
    check_eq("rr_order_2", issue_q[issue_q.size()-1], 1);
    idle(50);

    // overrun on channel 1 while the engine is busy
    tick_one(0, DW'($urandom));
    idle(5);
    tick_one(1, 24'h000AAA);
    idle(2);
    tick_one(1, 24'h000BBB);
    check_eq("overrun_set", overrun[1], 1'b1);
    wait_issue(100, at);
    check_eq("overrun_issue_ch", issue_q[$], 1);
    n1 = issue_q.size();
    idle(60);
    check_eq("overrun_single_issue", issue_q.size(), n1);
    step('0, sig, 1'b1);
    check_eq("overrun_cleared", overrun, '0);

    // engine never completes
    eng_dead = 1;
    tick_one(2, DW'($urandom));
    wait_issue(100, at);
`ifdef FIR_SCHED_TIMEOUT_EN
    idle(at + 64 - cyc);
    check_eq("timeout_set", timeout, 1'b1);
    eng_dead = 0;
    tick_one(3, DW'($urandom));
    wait_issue(200, at2);
    check_eq("timeout_redrain", at2, at + 113);
    idle(50);
    step('0, sig, 1'b1);
    check_eq("timeout_cleared", timeout, 1'b0);
`else
    idle(120);
    check_eq("hang_busy", busy, 1'b1);
    check_eq("hang_no_timeout", timeout, 1'b0);
    eng_dead = 0;
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    idle(60);
`endif

    // reset during WAIT abandons the job; stale done lands in DRAIN
    tick_one(0, DW'($urandom));
    wait_issue(100, at);
    idle(10);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    idle(60);
    k = cyc;
    tick_one(1, DW'($urandom));
    wait_issue(10, at);
    check_eq("post_reset_issue", at, k + 2);
    idle(50);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      t = '0; s = sig;
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 149) == 0) begin t[c] = 1'b1; s[c*DW +: DW] = DW'($urandom); end
      step(t, s, $urandom_range(0, 199) == 0);
    end
    idle(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: cycle=%0d", cyc);
    $fatal(1);
  end
endmodule
